// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - mnemonic, opcode and funct constants shared by the encoder and the control decoder
package instr_encoder_pkg;

    typedef enum logic [4:0] {
        MN_ADD  = 5'd0,  MN_SUB  = 5'd1,  MN_AND  = 5'd2,  MN_OR   = 5'd3,
        MN_NOR  = 5'd4,  MN_XOR  = 5'd5,  MN_SLT  = 5'd6,  MN_MULT = 5'd7,
        MN_DIV  = 5'd8,  MN_SLL  = 5'd9,  MN_SRL  = 5'd10, MN_SRA  = 5'd11,
        MN_J    = 5'd12, MN_BEQ  = 5'd13, MN_ADDI = 5'd14, MN_ANDI = 5'd15,
        MN_LW   = 5'd16, MN_SW   = 5'd17
    } mnem_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SHIFT = 6'b110000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;

    function automatic logic [5:0] funct_of(input logic [4:0] m);
        case (m)
            MN_ADD:  return FN_ADD;
            MN_SUB:  return FN_SUB;
            MN_AND:  return FN_AND;
            MN_OR:   return FN_OR;
            MN_NOR:  return FN_NOR;
            MN_XOR:  return FN_XOR;
            MN_SLT:  return FN_SLT;
            MN_MULT: return FN_MULT;
            MN_DIV:  return FN_DIV;
            MN_SRL:  return FN_SRL;
            MN_SRA:  return FN_SRA;
            default: return FN_SLL;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request/response bus between the instruction source and the encoder
interface instr_encoder_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [4:0]              mnem;
    logic [4:0]              rs;
    logic [4:0]              rt;
    logic [4:0]              rd;
    logic [4:0]              shamt;
    logic [15:0]             imm;
    logic [25:0]             target;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_word;
    logic [ADDR_W-1:0]       out_addr;
    logic                    illegal_op;
    logic [$clog2(DEPTH):0]  fifo_count;

    modport master (
        output in_valid, mnem, rs, rt, rd, shamt, imm, target, out_ready,
        input  in_ready, out_valid, out_word, out_addr, illegal_op, fifo_count
    );

    modport slave (
        input  in_valid, mnem, rs, rt, rd, shamt, imm, target, out_ready,
        output in_ready, out_valid, out_word, out_addr, illegal_op, fifo_count
    );
endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// rtl/instr_encoder_sync_fifo.sv - registered word FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // Storage is cleared on reset so the head reads 0 until the first push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - assembles instruction words from mnemonic+fields and streams them with byte addresses
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset,
    instr_encoder_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]       word_d;
    logic              legal_d;
    logic              accept, push, pop;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              illegal_q, illegal_d;

    always_comb begin
        word_d  = '0;
        legal_d = 1'b1;
        case (bus.mnem)
            MN_ADD, MN_SUB, MN_AND, MN_OR, MN_NOR, MN_XOR, MN_SLT, MN_MULT, MN_DIV:
                word_d = {OP_RTYPE, bus.rs, bus.rt, bus.rd, 5'd0, funct_of(bus.mnem)};
            MN_SLL, MN_SRL, MN_SRA:
                word_d = {OP_SHIFT, 5'd0, bus.rt, bus.rd, bus.shamt, funct_of(bus.mnem)};
            MN_J:    word_d = {OP_J, bus.target};
            MN_BEQ:  word_d = {OP_BEQ,  bus.rs, bus.rt, bus.imm};
            MN_ADDI: word_d = {OP_ADDI, bus.rs, bus.rt, bus.imm};
            MN_ANDI: word_d = {OP_ANDI, bus.rs, bus.rt, bus.imm};
            MN_LW:   word_d = {OP_LW,   bus.rs, bus.rt, bus.imm};
            MN_SW:   word_d = {OP_SW,   bus.rs, bus.rt, bus.imm};
            default: legal_d = 1'b0;
        endcase
    end

    // Illegal requests are still accepted so the source never stalls on them.
    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && legal_d;
    assign pop    = bus.out_valid && bus.out_ready;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (word_d),
        .pop_i   (pop),
        .data_o  (bus.out_word),
        .count_o (count)
    );

    assign addr_d    = pop ? addr_q + ADDR_W'(4) : addr_q;
    assign illegal_d = illegal_q || (accept && !legal_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= ADDR_W'(BASE_ADDR);
            illegal_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.fifo_count = count;
    assign bus.in_ready   = (count != CNT_W'(DEPTH));
    assign bus.out_valid  = (count != '0);
    assign bus.out_addr   = addr_q;
    assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against a queue-based model
module tb_instr_encoder;
    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 8;
    localparam int BASE_ADDR = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit [31:0] q[$];
    int        m_addr = BASE_ADDR;
    bit        m_ill  = 1'b0;

    int fn_tab[12] = '{32, 34, 36, 37, 39, 38, 42, 24, 26, 0, 2, 3};
    int iop_tab[5] = '{4, 8, 12, 35, 43};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] ref_word(input int m, input int rs, input int rt, input int rd,
                                           input int sh, input int imm, input int tgt,
                                           output bit legal);
        longint w;
        legal = 1'b1;
        if (m <= 8)       w = (longint'(rs) << 21) + (rt << 16) + (rd << 11) + fn_tab[m];
        else if (m <= 11) w = (longint'(48) << 26) + (rt << 16) + (rd << 11) + (sh << 6) + fn_tab[m];
        else if (m == 12) w = (longint'(2) << 26) + tgt;
        else if (m <= 17) w = (longint'(iop_tab[m-13]) << 26) + (longint'(rs) << 21) + (rt << 16) + imm;
        else begin
            w = 0;
            legal = 1'b0;
        end
        return w[31:0];
    endfunction

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input int m, input int rs, input int rt, input int rd,
                        input int sh, input int imm, input int tgt);
        bus.in_valid = 1'b1;
        bus.mnem = 5'(m);  bus.rs = 5'(rs);  bus.rt = 5'(rt);  bus.rd = 5'(rd);
        bus.shamt = 5'(sh); bus.imm = 16'(imm); bus.target = 26'(tgt);
    endtask

    // Called just after a falling edge with inputs set; checks state, then crosses one rising edge.
    task automatic step(output bit acc);
        bit m_ready, m_valid, do_pop, legal;
        bit [31:0] w;
        m_ready = (q.size() != DEPTH);
        m_valid = (q.size() != 0);
        check("in_ready",   bus.in_ready,   m_ready);
        check("out_valid",  bus.out_valid,  m_valid);
        check("fifo_count", bus.fifo_count, q.size());
        check("illegal_op", bus.illegal_op, m_ill);
        if (m_valid) begin
            check("out_word", bus.out_word, q[0]);
            check("out_addr", bus.out_addr, m_addr);
        end
        w = ref_word(int'(bus.mnem), int'(bus.rs), int'(bus.rt), int'(bus.rd),
                     int'(bus.shamt), int'(bus.imm), int'(bus.target), legal);
        acc    = bus.in_valid && m_ready;
        do_pop = m_valid && bus.out_ready;
        @(posedge clk);
        if (do_pop) begin
            void'(q.pop_front());
            m_addr = (m_addr + 4) % (1 << ADDR_W);
        end
        if (acc) begin
            if (legal) q.push_back(w);
            else       m_ill = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_fifo_count", bus.fifo_count, 0);
        check("rst_in_ready",   bus.in_ready,   1);
        check("rst_illegal_op", bus.illegal_op, 0);
        check("rst_out_addr",   bus.out_addr,   BASE_ADDR);
        check("rst_out_word",   bus.out_word,   0);
        q.delete();
        m_addr = BASE_ADDR;
        m_ill  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        idle();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) step(acc);
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        bit acc;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.mnem = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
        bus.shamt = '0; bus.imm = '0; bus.target = '0;
        @(negedge clk);
        pulse_reset();

        // ADD: one-cycle latency into an empty FIFO
        bus.out_ready = 1'b1;
        send(0, 1, 2, 3, 9, 16'hffff, 0);
        step(acc);
        idle();
        check("add_valid", bus.out_valid, 1);
        check("add_word",  bus.out_word,  32'h00221820);
        check("add_addr",  bus.out_addr,  8'h00);
        step(acc);

        // LW then J back-to-back
        pulse_reset();
        bus.out_ready = 1'b1;
        send(16, 29, 8, 0, 0, 16'h0004, 0);
        step(acc);
        check("lw_word", bus.out_word, 32'h8FA80004);
        check("lw_addr", bus.out_addr, 8'h00);
        send(12, 0, 0, 0, 0, 0, 26'h0000010);
        step(acc);
        idle();
        check("j_word", bus.out_word, 32'h08000010);
        check("j_addr", bus.out_addr, 8'h04);
        step(acc);

        // SRA zeroes the rs field
        send(11, 7, 5, 4, 2, 0, 0);
        step(acc);
        idle();
        check("sra_word", bus.out_word, 32'hC0052083);
        step(acc);

        // Backpressure: fill, block the fifth, then release
        pulse_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(14, i, i + 1, 0, 0, 16'h100 + i, 0);
            step(acc);
        end
        check("full_count", bus.fifo_count, 4);
        check("full_ready", bus.in_ready, 0);
        send(15, 3, 3, 0, 0, 16'h00ff, 0);
        step(acc);
        check("fifth_blocked", acc, 0);
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 4 && !acc; k++) step(acc);
        check("fifth_accepted", acc, 1);
        drain();

        // Illegal mnemonic then ADD
        pulse_reset();
        bus.out_ready = 1'b1;
        send(25, 1, 1, 1, 1, 1, 1);
        step(acc);
        send(0, 1, 2, 3, 0, 0, 0);
        step(acc);
        idle();
        check("ill_sticky", bus.illegal_op, 1);
        check("ill_add_word", bus.out_word, 32'h00221820);
        check("ill_add_addr", bus.out_addr, 8'h00);
        step(acc);

        // Reset mid-stream with words buffered and illegal_op set
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(1, i, i, i, 0, 0, 0);
            step(acc);
        end
        idle();
        pulse_reset();

        // Long stream wraps the address counter
        bus.out_ready = 1'b1;
        for (int i = 0; i < 70; i++) begin
            send(0, i % 32, (i + 1) % 32, (i + 2) % 32, 0, 0, 0);
            step(acc);
        end
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 500; i++) begin
            int m;
            m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(18, 31)) : int'($urandom_range(0, 17));
            if ($urandom_range(0, 4) != 0)
                send(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 65535), int'($urandom & 32'h03ffffff));
            else
                idle();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Assembles MIPS-style instruction words from mnemonic plus field inputs.
- Sits in front of instruction memory; feeds the processor's opcode decoder, which is the other end of this block.
- Buffers encoded words in a small FIFO and streams them out with addresses to the imem write port.
- Used for program loading and for self-check stimulus.

Parameters:
- DEPTH, 4, output FIFO depth in words (power of two, ≥2)
- ADDR_W, 8, byte-address width of out_addr
- BASE_ADDR, 0, first byte address emitted after reset

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request carries a valid instruction
- in_ready  out  1  encoder can accept a request
- mnem  in  5  mnemonic code (see Behaviour)
- rs  in  5  source register
- rt  in  5  target register
- rd  in  5  destination register
- shamt  in  5  shift amount
- imm  in  16  I-type immediate
- target  in  26  J-type target
- out_valid  out  1  out_word/out_addr valid
- out_ready  in  1  imem writer consumes word
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_word
- illegal_op  out  1  sticky: an unknown mnemonic was accepted
- fifo_count  out  $clog2(DEPTH)+1  words currently buffered

Behaviour:
- Mnemonic codes and encodings:
  - 0..8 = ADD, SUB, AND, OR, NOR, XOR, SLT, MULT, DIV. Opcode 000000, funct 100000, 100010, 100100, 100101, 100111, 100110, 101010, 011000, 011010.
  - 9..11 = SLL, SRL, SRA. Opcode 110000, funct 000000, 000010, 000011.
  - 12 = J, opcode 000010.
  - 13 = BEQ, opcode 000100.
  - 14 = ADDI, opcode 001000.
  - 15 = ANDI, opcode 001100.
  - 16 = LW, opcode 100011.
  - 17 = SW, opcode 101011.
  - 18..31 are illegal.
- Field formats:
  - R-format: {op, rs, rt, rd, shamt, funct}. shamt is forced to 0 for codes 0..8.
  - Shifts: rs field forced to 0.
  - I-format: {op, rs, rt, imm}.
  - J-format: {op, target}.
  - Unused inputs are ignored.
- Handshake: a request is accepted when in_valid && in_ready. in_ready = (fifo_count != DEPTH), derived combinationally from registered count.
- Encoding is combinational; the accepted word is written into the FIFO at the accepting edge. Latency is 1: out_valid rises the cycle after the first accept into an empty FIFO.
- Output side:
  - out_valid = (fifo_count != 0).
  - out_word is the FIFO head, always registered.
  - Transfer occurs on out_valid && out_ready. Data must hold stable while out_valid && !out_ready.
- Address counter:
  - Reset value BASE_ADDR.
  - Increments by 4 on each output transfer, modulo 2^ADDR_W. After 0xFC with ADDR_W=8, the next address is 0x00.
  - out_addr = counter.
- Simultaneous push and pop: count unchanged, both occur. A push when full is impossible because in_ready=0. Pointers wrap modulo DEPTH.
- Illegal mnemonic:
  - The request is accepted (consumes in_ready), nothing is pushed, and the address is not advanced.
  - illegal_op sets the next cycle and holds until reset.
- Reset, async at any time including mid-stream:
  - FIFO pointers and count go to 0, so out_valid=0 and in_ready=1 immediately.
  - out_addr=BASE_ADDR, illegal_op=0, out_word=0.
  - Contents are discarded; no partial word is ever emitted.

Decomposition:
- Shared package holds:
  - Mnemonic enum (5-bit).
  - Opcode constants: OP_RTYPE, OP_SHIFT, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW.
  - Funct constants.
  - The same constants are consumed by the control decoder so that both ends agree.
- One sub-module: sync_fifo (parameterised width/depth, count output). Encoder logic stays in the top module.

Test Plan:
- ADD rs=1 rt=2 rd=3, out_ready=1 → one cycle later out_valid=1, out_word=0x00221820, out_addr=0x00.
- LW rs=29 rt=8 imm=0x0004, then J target=0x0000010, back-to-back → words 0x8FA80004 @0x00, then 0x08000010 @0x04.
- SRA rt=5 rd=4 shamt=2 rs=7 → 0xC0052083; rs field is zeroed.
- out_ready=0, push 5 requests with DEPTH=4:
  - in_ready=0 after the 4th, fifo_count=4, out_word stable.
  - Then out_ready=1 → addresses 0x00, 0x04, 0x08, 0x0C in order, and the 5th request is accepted once a slot frees.
- mnem=25 accepted, then ADD → illegal_op=1 sticky, no word for code 25, ADD emitted at 0x00.
- Issue 3 pushes with out_ready=0, assert reset mid-cycle → out_valid, fifo_count and illegal_op drop immediately. After release, the next word is emitted at BASE_ADDR; run 64 words to check the address wrap 0xFC→0x00.
